// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side scheduler: FSM encoding and
// default widths.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int GRANT_W            = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        WAIT_FALL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans from ptr+1 upward with wrap and
// returns the first requester found as one-hot plus index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        // k runs to NUM_REQ so the last-granted requester is also eligible
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Define UART_ARB_PAR_CFG_EN to add per-requester parity configuration.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
`ifdef UART_ARB_PAR_CFG_EN
    input  logic [2*NUM_REQ-1:0]          REQ_PAR_CFG,
`endif
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic                          TX_BUSY,
    output logic [DATA_WIDTH-1:0]         P_DATA,
    output logic                          DATA_VALID,
    output logic                          PAR_EN,
    output logic                          PAR_TYP,
    output logic [GRANT_W-1:0]            GRANT_ID,
    output logic                          ARB_BUSY,
    output logic                          TX_ERR
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_t            state_q, state_n;
    logic [IDX_W-1:0]      ptr_q, ptr_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_n;
    logic [GRANT_W-1:0]    grant_id_q, grant_id_n;
    logic [NUM_REQ-1:0]    ready_q, ready_n;
    logic                  dv_q, dv_n;
    logic                  err_q, err_n;
    logic                  busy_q, busy_n;
    logic                  par_en_q, par_en_n;
    logic                  par_typ_q, par_typ_n;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (REQ_VALID),
        .ptr   (ptr_q),
        .grant (pick_onehot),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_INIT;
            cnt_q      <= '0;
            p_data_q   <= '0;
            grant_id_q <= '0;
            ready_q    <= '0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            ptr_q      <= ptr_n;
            cnt_q      <= cnt_n;
            p_data_q   <= p_data_n;
            grant_id_q <= grant_id_n;
            ready_q    <= ready_n;
            dv_q       <= dv_n;
            err_q      <= err_n;
            busy_q     <= busy_n;
            par_en_q   <= par_en_n;
            par_typ_q  <= par_typ_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        ptr_n      = ptr_q;
        cnt_n      = cnt_q;
        p_data_n   = p_data_q;
        grant_id_n = grant_id_q;
        par_en_n   = par_en_q;
        par_typ_n  = par_typ_q;
        ready_n    = '0;
        dv_n       = 1'b0;
        err_n      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!TX_BUSY && pick_found) begin
                    dv_n       = 1'b1;
                    ready_n    = pick_onehot;
                    grant_id_n = GRANT_W'(pick_idx);
                    ptr_n      = pick_idx;
                    p_data_n   = REQ_DATA[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifdef UART_ARB_PAR_CFG_EN
                    par_en_n   = REQ_PAR_CFG[2*int'(pick_idx)];
                    par_typ_n  = REQ_PAR_CFG[2*int'(pick_idx)+1];
`endif
                    cnt_n      = '0;
                    state_n    = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                // An aborted byte is dropped; the requester was already acknowledged
                if (TX_BUSY) begin
                    state_n = WAIT_FALL;
                end else if (cnt_q == CNT_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!TX_BUSY) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    assign REQ_READY  = ready_q;
    assign P_DATA     = p_data_q;
    assign DATA_VALID = dv_q;
    assign PAR_EN     = par_en_q;
    assign PAR_TYP    = par_typ_q;
    assign GRANT_ID   = grant_id_q;
    assign ARB_BUSY   = busy_q;
    assign TX_ERR     = err_q;

endmodule
